// File: rtl/seg_btn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_btn_pkg
//  Description : Shared constants and helpers for the seg_btn_io front-panel
//                controller: hex-to-7-segment table, dark-digit cathode
//                pattern, blink phase type and auto-repeat multipliers.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg_btn_pkg;

    // Cathode pattern for a dark digit (all segments off, active-low)
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Auto-repeat timing in units of SCAN_DIV clock cycles
    localparam int RPT_DELAY_MULT = 32;
    localparam int RPT_RATE_MULT  = 8;

    typedef enum logic {
        BLINK_OFF = 1'b0,
        BLINK_ON  = 1'b1
    } blink_phase_e;

    // Active-low cathodes, bit6 = g ... bit0 = a
    function automatic logic [6:0] hex2seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_btn_io_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : One push-button channel: 2-flop synchroniser, counting
//                debouncer, rising-edge press pulse and (when the macro
//                SEG_BTN_AUTOREPEAT_EN is defined) hold-to-repeat pulses.
//  Ports       : clk    - clock
//                rst_n  - synchronous active-low reset
//                btn    - raw asynchronous button, active-high
//                level  - debounced level
//                pulse  - one-cycle press (and repeat) pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce
    import seg_btn_pkg::*;
#(
    parameter int DEB_CYC  = 16
`ifdef SEG_BTN_AUTOREPEAT_EN
    ,
    parameter int SCAN_DIV = 64
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic pulse
);

    localparam int CW = $clog2(DEB_CYC);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic          pulse_q;
    logic          pulse_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          rise;

    // Counter only advances while the synced sample disagrees with the
    // accepted level; any agreeing sample restarts the qualification.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEB_CYC - 1)) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign rise = level_d & ~level_q;

`ifdef SEG_BTN_AUTOREPEAT_EN
    localparam int RPT_DELAY = RPT_DELAY_MULT * SCAN_DIV;
    localparam int RPT_RATE  = RPT_RATE_MULT * SCAN_DIV;
    localparam int RW        = $clog2(RPT_DELAY);

    logic [RW-1:0] rpt_cnt_q;
    logic [RW-1:0] rpt_cnt_d;
    logic          rpt_first_q;
    logic          rpt_first_d;
    logic          rpt_fire;

    // Counter starts from zero on the press edge, so the first repeat lands
    // exactly RPT_DELAY cycles after the press pulse, then every RPT_RATE.
    always_comb begin
        rpt_cnt_d   = '0;
        rpt_first_d = 1'b1;
        rpt_fire    = 1'b0;
        if (level_q && level_d) begin
            rpt_first_d = rpt_first_q;
            if ((rpt_first_q && (rpt_cnt_q == RW'(RPT_DELAY - 1))) ||
                (!rpt_first_q && (rpt_cnt_q == RW'(RPT_RATE - 1)))) begin
                rpt_fire    = 1'b1;
                rpt_first_d = 1'b0;
            end else begin
                rpt_cnt_d = rpt_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rpt_cnt_q   <= '0;
            rpt_first_q <= 1'b1;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_first_q <= rpt_first_d;
        end
    end

    assign pulse_d = rise | rpt_fire;
`else
    assign pulse_d = rise;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            level_q <= level_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign pulse = pulse_q;

endmodule
`default_nettype wire

// File: rtl/seg_btn_io.sv
`default_nettype none
// ============================================================================
//  Module      : seg_btn_io
//  Description : Parametrised front-panel controller: NBTN debounced buttons
//                with press pulses, NDIG-digit multiplexed hex 7-segment
//                display with per-digit blanking and completion blinking.
//                Optional macro SEG_BTN_AUTOREPEAT_EN enables hold-to-repeat
//                button pulses.
//  Ports       : clk, rst_n    - clock, synchronous active-low reset
//                btn           - raw buttons (NBTN)
//                btn_level     - debounced levels (NBTN)
//                btn_pulse     - press pulses (NBTN)
//                disp_val      - hex nibble per digit (4*NDIG)
//                disp_blank    - per-digit dark request (NDIG)
//                comp          - puzzle complete, enables blinking
//                seg           - [6:0] cathodes, [7] dp, [8+i] anodes,
//                                all active-low
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_btn_io
    import seg_btn_pkg::*;
#(
    parameter int NDIG        = 4,
    parameter int NBTN        = 5,
    parameter int DEB_CYC     = 16,
    parameter int SCAN_DIV    = 64,
    parameter int BLINK_SCANS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NBTN-1:0]       btn,
    output logic [NBTN-1:0]       btn_level,
    output logic [NBTN-1:0]       btn_pulse,
    input  logic [4*NDIG-1:0]     disp_val,
    input  logic [NDIG-1:0]       disp_blank,
    input  logic                  comp,
    output logic [8+NDIG-1:0]     seg
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int FW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

    genvar gi;
    generate
        for (gi = 0; gi < NBTN; gi++) begin : g_btn
            btn_debounce #(
                .DEB_CYC  (DEB_CYC)
`ifdef SEG_BTN_AUTOREPEAT_EN
                ,
                .SCAN_DIV (SCAN_DIV)
`endif
            ) u_btn (
                .clk   (clk),
                .rst_n (rst_n),
                .btn   (btn[gi]),
                .level (btn_level[gi]),
                .pulse (btn_pulse[gi])
            );
        end
    endgenerate

    logic [SW-1:0]     scan_cnt_q;
    logic [SW-1:0]     scan_cnt_d;
    logic [IW-1:0]     dig_idx_q;
    logic [IW-1:0]     dig_idx_d;
    logic [FW-1:0]     frame_cnt_q;
    logic [FW-1:0]     frame_cnt_d;
    blink_phase_e      blink_q;
    blink_phase_e      blink_d;
    logic [8+NDIG-1:0] seg_q;
    logic [8+NDIG-1:0] seg_d;

    logic              scan_wrap;
    logic              frame_wrap;
    logic              dark;
    logic [3:0]        nibble;
    logic [NDIG-1:0]   anodes;

    always_comb begin
        scan_wrap   = (scan_cnt_q == SW'(SCAN_DIV - 1));
        frame_wrap  = scan_wrap && (dig_idx_q == IW'(NDIG - 1));

        scan_cnt_d  = scan_wrap ? '0 : scan_cnt_q + 1'b1;
        dig_idx_d   = dig_idx_q;
        if (scan_wrap) begin
            dig_idx_d = frame_wrap ? '0 : dig_idx_q + 1'b1;
        end

        // Blink phase only runs while comp is set; dropping comp restarts
        // the next blink cycle from a full lit half-period.
        frame_cnt_d = frame_cnt_q;
        blink_d     = blink_q;
        if (!comp) begin
            frame_cnt_d = '0;
            blink_d     = BLINK_ON;
        end else if (frame_wrap) begin
            if (frame_cnt_q == FW'(BLINK_SCANS - 1)) begin
                frame_cnt_d = '0;
                blink_d     = (blink_q == BLINK_ON) ? BLINK_OFF : BLINK_ON;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end

        // Output image is built from the current index and registered, so
        // seg trails an index change by one cycle. comp is used directly so
        // its fall lights the display on the very next update.
        nibble = disp_val[dig_idx_q*4 +: 4];
        dark   = disp_blank[dig_idx_q] | (comp & (blink_q == BLINK_OFF));
        anodes = '1;
        if (!dark) begin
            anodes[dig_idx_q] = 1'b0;
        end
        seg_d = {anodes, 1'b1, (dark ? SEG_OFF : hex2seg(nibble))};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_cnt_q  <= '0;
            dig_idx_q   <= '0;
            frame_cnt_q <= '0;
            blink_q     <= BLINK_ON;
            seg_q       <= '1;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            dig_idx_q   <= dig_idx_d;
            frame_cnt_q <= frame_cnt_d;
            blink_q     <= blink_d;
            seg_q       <= seg_d;
        end
    end

    assign seg = seg_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_btn_io.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_btn_io
//  Description : Self-checking directed testbench for seg_btn_io with the
//                default parameter set (4 digits, 5 buttons, DEB_CYC=16,
//                SCAN_DIV=64, BLINK_SCANS=8). Honours SEG_BTN_AUTOREPEAT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_btn_io;

    logic        clk;
    logic        rst_n;
    logic [4:0]  btn;
    logic [4:0]  btn_level;
    logic [4:0]  btn_pulse;
    logic [15:0] disp_val;
    logic [3:0]  disp_blank;
    logic        comp;
    logic [11:0] seg;

    int total = 0;
    int bad   = 0;

    logic [6:0] tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg_btn_io #(
        .NDIG        (4),
        .NBTN        (5),
        .DEB_CYC     (16),
        .SCAN_DIV    (64),
        .BLINK_SCANS (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn        (btn),
        .btn_level  (btn_level),
        .btn_pulse  (btn_pulse),
        .disp_val   (disp_val),
        .disp_blank (disp_blank),
        .comp       (comp),
        .seg        (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // Expected seg image for digit d of value v, or the dark image
    function automatic logic [11:0] exp_seg(input int d, input bit dk, input logic [15:0] v);
        logic [3:0] an;
        logic [3:0] n;
        if (dk) return 12'hFFF;
        an = 4'hF & ~(4'b0001 << d);
        n  = v[d*4 +: 4];
        return {an, 1'b1, tab[n]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            btn = 5'($urandom);
            tick();
            total++;
            if (seg !== 12'hFFF) begin
                bad++; $display("FAIL reset_seg c=%0d got=%h exp=fff", c, seg);
            end
            total++;
            if (btn_level !== 5'h00) begin
                bad++; $display("FAIL reset_level c=%0d got=%h exp=00", c, btn_level);
            end
            total++;
            if (btn_pulse !== 5'h00) begin
                bad++; $display("FAIL reset_pulse c=%0d got=%h exp=00", c, btn_pulse);
            end
        end
        btn   = '0;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) tick();
    endtask

    task automatic test_debounce();
        logic [4:0] ep;
        logic [4:0] el;
        btn = '0;
        // bounce btn[2] every 5 cycles: no level change, no pulse
        for (int c = 0; c < 60; c++) begin
            if (c % 5 == 0) btn[2] = ~btn[2];
            tick();
            total++;
            if (btn_pulse !== 5'h00 || btn_level !== 5'h00) begin
                bad++; $display("FAIL bounce c=%0d got=%h/%h exp=00/00", c, btn_level, btn_pulse);
            end
        end
        btn[2] = 1'b1;
        for (int n = 1; n <= 25; n++) begin
            tick();
            ep = (n == 18) ? 5'b00100 : 5'b00000;
            el = (n >= 18) ? 5'b00100 : 5'b00000;
            total++;
            if (btn_pulse !== ep || btn_level !== el) begin
                bad++; $display("FAIL press n=%0d got=%h/%h exp=%h/%h", n, btn_level, btn_pulse, el, ep);
            end
        end
        // release: level falls after the same latency, never a pulse
        btn[2] = 1'b0;
        for (int n = 1; n <= 25; n++) begin
            tick();
            el = (n < 18) ? 5'b00100 : 5'b00000;
            total++;
            if (btn_pulse !== 5'h00 || btn_level !== el) begin
                bad++; $display("FAIL release n=%0d got=%h/%h exp=%h/00", n, btn_level, btn_pulse, el);
            end
        end
    endtask

    task automatic test_glitch();
        logic [4:0] ep;
        logic [4:0] el;
        // DEB_CYC-1 cycles high is rejected
        btn[1] = 1'b1;
        for (int n = 1; n <= 45; n++) begin
            if (n == 16) btn[1] = 1'b0;
            tick();
            total++;
            if (btn_pulse !== 5'h00 || btn_level !== 5'h00) begin
                bad++; $display("FAIL glitch15 n=%0d got=%h/%h exp=00/00", n, btn_level, btn_pulse);
            end
            if (n == 15) btn[1] = 1'b0;
        end
        // exactly DEB_CYC cycles high is accepted
        btn[1] = 1'b1;
        for (int n = 1; n <= 45; n++) begin
            tick();
            if (n == 16) btn[1] = 1'b0;
            ep = (n == 18) ? 5'b00010 : 5'b00000;
            el = (n >= 18 && n < 34) ? 5'b00010 : 5'b00000;
            total++;
            if (btn_pulse !== ep || btn_level !== el) begin
                bad++; $display("FAIL glitch16 n=%0d got=%h/%h exp=%h/%h", n, btn_level, btn_pulse, el, ep);
            end
        end
    endtask

    task automatic test_reset_mid();
        // reset part-way through a debounce must restart qualification
        btn[3] = 1'b1;
        for (int n = 0; n < 10; n++) tick();
        rst_n = 1'b0;
        tick();
        total++;
        if (seg !== 12'hFFF || btn_level !== 5'h00 || btn_pulse !== 5'h00) begin
            bad++; $display("FAIL reset_mid got=%h/%h/%h exp=fff/00/00", seg, btn_level, btn_pulse);
        end
        rst_n = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            total++;
            if (btn_level !== ((n >= 18) ? 5'b01000 : 5'b00000)) begin
                bad++; $display("FAIL reset_mid_level n=%0d got=%h exp=%h", n, btn_level,
                                ((n >= 18) ? 5'b01000 : 5'b00000));
            end
        end
        btn[3] = 1'b0;
        for (int n = 0; n < 20; n++) tick();
    endtask

    task automatic test_scan();
        logic [11:0] e;
        logic [15:0] v;
        v          = 16'h1A3F;
        disp_val   = v;
        disp_blank = 4'b0000;
        comp       = 1'b0;
        do_reset();
        for (int k = 1; k <= 320; k++) begin
            tick();
            e = exp_seg(((k - 1) / 64) % 4, 1'b0, v);
            total++;
            if (seg !== e) begin
                bad++; $display("FAIL scan k=%0d got=%h exp=%h", k, seg, e);
            end
            // value change mid-slot shows on the next clock
            if (k == 100) begin
                v        = 16'h1A8F;
                disp_val = v;
            end
        end
    endtask

    task automatic test_blank();
        logic [11:0] e;
        int d;
        disp_val   = 16'h1A3F;
        disp_blank = 4'b0100;
        comp       = 1'b0;
        do_reset();
        for (int k = 1; k <= 320; k++) begin
            tick();
            d = ((k - 1) / 64) % 4;
            e = exp_seg(d, d == 2, 16'h1A3F);
            total++;
            if (seg !== e) begin
                bad++; $display("FAIL blank k=%0d got=%h exp=%h", k, seg, e);
            end
        end
        disp_blank = 4'b0000;
    endtask

    task automatic test_blink();
        logic [11:0] e;
        bit dk;
        disp_val   = 16'h1A3F;
        disp_blank = 4'b0000;
        comp       = 1'b1;
        do_reset();
        for (int k = 1; k <= 6260; k++) begin
            tick();
            dk = (k <= 6200) && ((((k - 1) / 2048) % 2) == 1);
            e  = exp_seg(((k - 1) / 64) % 4, dk, 16'h1A3F);
            total++;
            if (seg !== e) begin
                bad++; $display("FAIL blink k=%0d got=%h exp=%h", k, seg, e);
            end
            // drop comp in the middle of an off half-period
            if (k == 6200) comp = 1'b0;
        end
    endtask

    task automatic test_repeat();
        logic [4:0] ep;
        bit p;
        btn = 5'b00001;
        for (int n = 1; n <= 5000; n++) begin
            tick();
`ifdef SEG_BTN_AUTOREPEAT_EN
            p = (n == 18) || (n >= 2066 && ((n - 2066) % 512) == 0);
`else
            p = (n == 18);
`endif
            ep = p ? 5'b00001 : 5'b00000;
            total++;
            if (btn_pulse !== ep) begin
                bad++; $display("FAIL hold n=%0d got=%h exp=%h", n, btn_pulse, ep);
            end
        end
        btn = '0;
        for (int n = 1; n <= 700; n++) begin
            tick();
            total++;
            if (btn_pulse !== 5'h00) begin
                bad++; $display("FAIL after_release n=%0d got=%h exp=00", n, btn_pulse);
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        btn        = '0;
        disp_val   = '0;
        disp_blank = '0;
        comp       = 1'b0;
        test_reset();
        test_debounce();
        test_glitch();
        test_reset_mid();
        test_scan();
        test_blank();
        test_blink();
        test_repeat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
